// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation magnitude search:
// FSM state encoding, default width and the comparator-flag sanity check.
package sar_pkg;

  localparam int SAR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } sar_state_t;

  // A trustworthy comparator asserts exactly one of its three outcome flags.
  function automatic logic flags_one_hot(input logic lt, input logic gt, input logic eq);
    return ({lt, gt, eq} == 3'b100) || ({lt, gt, eq} == 3'b010) || ({lt, gt, eq} == 3'b001);
  endfunction

endpackage

// File: rtl/sar_mag_search.sv
// Successive-approximation search recovering an unknown magnitude A from an
// external comparator's LT/GT/EQ flags, MSB first. Optional SAR_EARLY_EXIT_EN
// ends the search on the first exact match.
module sar_mag_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             A_LT_B,
  input  logic             A_GT_B,
  input  logic             A_EQ_B,
  output logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] B_MSB   = WIDTH'(1) << (WIDTH - 1);

  sar_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] trial_b;
  logic             early_eq;

`ifdef SAR_EARLY_EXIT_EN
  assign early_eq = A_EQ_B;
`else
  assign early_eq = 1'b0;
`endif

  // ---- state register: all search state, cleared asynchronously ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      B      <= '0;
      idx    <= IDX_TOP;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      B      <= b_nxt;
      idx    <= idx_nxt;
      result <= result_nxt;
      err    <= err_nxt;
    end
  end

  // ---- next-state / decision logic ----
  always_comb begin
    state_nxt  = state;
    b_nxt      = B;
    idx_nxt    = idx;
    result_nxt = result;
    err_nxt    = err;
    trial_b    = B;

    unique case (state)
      IDLE: begin
        if (start) begin
          b_nxt     = B_MSB;
          idx_nxt   = IDX_TOP;
          err_nxt   = 1'b0;
          state_nxt = TRIAL;
        end
      end

      TRIAL: begin
        if (!flags_one_hot(A_LT_B, A_GT_B, A_EQ_B)) begin
          // Comparator misbehaved: report the partial value and bail out.
          err_nxt    = 1'b1;
          result_nxt = B;
          b_nxt      = '0;
          state_nxt  = DONE;
        end else begin
          if (A_LT_B) trial_b[idx] = 1'b0;
          if (early_eq) begin
            result_nxt = B;
            b_nxt      = '0;
            state_nxt  = DONE;
          end else if (idx == '0) begin
            result_nxt = trial_b;
            b_nxt      = '0;
            state_nxt  = DONE;
          end else begin
            trial_b[idx - 1'b1] = 1'b1;
            b_nxt               = trial_b;
            idx_nxt             = idx - 1'b1;
          end
        end
      end

      DONE: begin
        b_nxt     = '0;
        idx_nxt   = IDX_TOP;
        state_nxt = IDLE;
      end

      default: begin
        b_nxt     = '0;
        idx_nxt   = IDX_TOP;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == TRIAL);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sar_mag_search.sv
// Self-checking bench: closes the loop with a behavioural comparator and checks
// B trial sequences, latency, result and err against an arithmetic model.
module tb_sar_mag_search;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bad = 1'b0;
  logic [W-1:0] a_val = '0;
  logic         A_LT_B, A_GT_B, A_EQ_B;
  logic [W-1:0] B, result;
  logic         busy, done, err;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] obs_b[$];
  int           obs_done_cyc;
  int           obs_done_cnt;
  logic [W-1:0] obs_res;
  logic         obs_err;

  always #5 clk = ~clk;

  assign A_LT_B = bad ? 1'b0 : (a_val < B);
  assign A_GT_B = bad ? 1'b0 : (a_val > B);
  assign A_EQ_B = bad ? 1'b0 : (a_val == B);

  sar_mag_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A_LT_B(A_LT_B), .A_GT_B(A_GT_B), .A_EQ_B(A_EQ_B),
    .B(B), .busy(busy), .done(done), .result(result), .err(err)
  );

  // Trial k (1-based) keeps the top k-1 bits of A and probes bit W-k.
  function automatic logic [W-1:0] exp_trial_b(input logic [W-1:0] a, input int k);
    int av = int'(a);
    int sh = W - k + 1;
    return W'(((av >> sh) << sh) | (1 << (W - k)));
  endfunction

  function automatic int exp_trials(input logic [W-1:0] a);
`ifdef SAR_EARLY_EXIT_EN
    for (int k = 1; k <= W; k++)
      if (exp_trial_b(a, k) == a) return k;
`endif
    return W;
  endfunction

  task automatic run_search(input logic [W-1:0] a, input int bad_cyc, input int restart_cyc);
    obs_b.delete();
    obs_done_cyc = -1;
    obs_done_cnt = 0;
    obs_res = '0;
    obs_err = 1'b0;
    @(negedge clk);
    a_val = a;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      bad   = (cyc == bad_cyc);
      start = (cyc == restart_cyc);
      @(negedge clk);
      if (busy) obs_b.push_back(B);
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = cyc;
          obs_res = result;
          obs_err = err;
        end
      end
      @(posedge clk);
      #1;
      if (obs_done_cyc > 0 && cyc >= obs_done_cyc + 2) break;
    end
    bad = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({B, busy, done, result, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got B=%b busy=%b done=%b result=%b err=%b, need all 0", B, busy, done, result, err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, need 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] seq [4];
    seq[0] = 4'b1000; seq[1] = 4'b1100; seq[2] = 4'b1010; seq[3] = 4'b1011;
    run_search(4'b1011, 0, 0);
    checks++;
    if (obs_b.size() != 4) begin
      errors++;
      $display("FAIL dir_trial_count: got %0d, need 4", obs_b.size());
    end
    for (int k = 0; k < 4 && k < obs_b.size(); k++) begin
      checks++;
      if (obs_b[k] !== seq[k]) begin
        errors++;
        $display("FAIL dir_b_seq[%0d]: got %b, need %b", k, obs_b[k], seq[k]);
      end
    end
    checks++;
    if (obs_res !== 4'b1011 || obs_done_cyc != 5 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL dir_result: got result=%b done_cyc=%0d err=%b, need 1011 5 0", obs_res, obs_done_cyc, obs_err);
    end
    run_search(4'b1000, 0, 0);
    checks++;
    if (obs_res !== 4'b1000 || obs_done_cyc != exp_trials(4'b1000) + 1) begin
      errors++;
      $display("FAIL dir_1000: got result=%b done_cyc=%0d, need 1000 %0d", obs_res, obs_done_cyc, exp_trials(4'b1000) + 1);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] vals [2];
    vals[0] = 4'b0000;
    vals[1] = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      run_search(vals[i], 0, 0);
      checks++;
      if (obs_res !== vals[i] || obs_done_cyc != 5 || obs_b.size() != 4) begin
        errors++;
        $display("FAIL boundary_%b: got result=%b done_cyc=%0d trials=%0d, need %b 5 4",
                 vals[i], obs_res, obs_done_cyc, obs_b.size(), vals[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    int t;
    for (int n = 0; n < 16; n++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      t = exp_trials(a);
      run_search(a, 0, 0);
      checks++;
      if (obs_res !== a || obs_done_cyc != t + 1 || obs_err !== 1'b0 || obs_done_cnt != 1) begin
        errors++;
        $display("FAIL rand_result a=%b: got result=%b done_cyc=%0d err=%b pulses=%0d, need %b %0d 0 1",
                 a, obs_res, obs_done_cyc, obs_err, obs_done_cnt, a, t + 1);
      end
      checks++;
      if (obs_b.size() != t) begin
        errors++;
        $display("FAIL rand_trials a=%b: got %0d, need %0d", a, obs_b.size(), t);
      end
      for (int k = 0; k < t && k < obs_b.size(); k++) begin
        checks++;
        if (obs_b[k] !== exp_trial_b(a, k + 1)) begin
          errors++;
          $display("FAIL rand_b_seq a=%b k=%0d: got %b, need %b", a, k, obs_b[k], exp_trial_b(a, k + 1));
        end
      end
    end
  endtask

  task automatic test_bad_flags();
    run_search(4'b1011, 2, 0);
    checks++;
    if (obs_err !== 1'b1 || obs_done_cyc != 3 || obs_res !== exp_trial_b(4'b1011, 2)) begin
      errors++;
      $display("FAIL bad_flags: got err=%b done_cyc=%0d result=%b, need 1 3 %b",
               obs_err, obs_done_cyc, obs_res, exp_trial_b(4'b1011, 2));
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_held: got %b, need 1", err);
    end
    run_search(4'b0110, 0, 0);
    checks++;
    if (obs_err !== 1'b0 || obs_res !== 4'b0110) begin
      errors++;
      $display("FAIL err_clear: got err=%b result=%b, need 0 0110", obs_err, obs_res);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    a_val = 4'b0101;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({B, busy, done, result, err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got B=%b busy=%b done=%b result=%b err=%b, need all 0", B, busy, done, result, err);
    end
    @(negedge clk);
    rst = 1'b0;
    run_search(4'b0101, 0, 0);
    checks++;
    if (obs_res !== 4'b0101 || obs_done_cyc != exp_trials(4'b0101) + 1) begin
      errors++;
      $display("FAIL after_reset: got result=%b done_cyc=%0d, need 0101 %0d", obs_res, obs_done_cyc, exp_trials(4'b0101) + 1);
    end
  endtask

  task automatic test_restart_ignored();
    run_search(4'b0011, 0, 2);
    checks++;
    if (obs_done_cnt != 1 || obs_res !== 4'b0011 || obs_done_cyc != exp_trials(4'b0011) + 1) begin
      errors++;
      $display("FAIL restart_ignored: got pulses=%0d result=%b done_cyc=%0d, need 1 0011 %0d",
               obs_done_cnt, obs_res, obs_done_cyc, exp_trials(4'b0011) + 1);
    end
  endtask

  task automatic test_back_to_back();
    int got[$];
    int expd[$];
    logic [W-1:0] a;
    logic [W-1:0] res_seen[$];
    int t, d;
    a = W'($urandom_range(0, (1 << W) - 1));
    t = exp_trials(a);
    d = t + 1;
    while (d <= 13) begin
      expd.push_back(d);
      d = d + t + 2;
    end
    @(negedge clk);
    a_val = a;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      if (done) begin
        got.push_back(cyc);
        res_seen.push_back(result);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    checks++;
    if (got.size() != expd.size()) begin
      errors++;
      $display("FAIL b2b_pulses a=%b: got %0d, need %0d", a, got.size(), expd.size());
    end
    for (int i = 0; i < got.size() && i < expd.size(); i++) begin
      checks++;
      if (got[i] != expd[i] || res_seen[i] !== a) begin
        errors++;
        $display("FAIL b2b_done[%0d]: got cycle %0d result %b, need cycle %0d result %b", i, got[i], res_seen[i], expd[i], a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_random();
    test_bad_flags();
    test_mid_reset();
    test_restart_ignored();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
